// File: rtl/alu_prog_issuer_if.sv
// alu_prog_issuer_if
//   Bundles the host-programming, instruction-stream and result signals of
//   alu_prog_issuer.
//   master : the issuer side (drives instr_out/valid, result, busy, done).
//   slave  : the host/ALU side (drives program writes, start, ready, result_in).
//   Optional macro ALU_ISSUER_CSUM_EN adds csum (issuer output).
//
//   Handshake: a byte moves from issuer to ALU on every rising clk edge where
//   instr_valid && instr_ready. Once instr_valid is high, instr_out is held
//   stable and instr_valid stays high until that transfer happens. instr_ready
//   is ignored while instr_valid is low.
interface alu_prog_issuer_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          start;
  logic [7:0]    instr_out;
  logic          instr_valid;
  logic          instr_ready;
  logic [7:0]    result_in;
  logic [7:0]    result;
  logic          result_valid;
  logic          busy;
  logic          done;
`ifdef ALU_ISSUER_CSUM_EN
  logic [7:0]    csum;
`endif

  modport master (
`ifdef ALU_ISSUER_CSUM_EN
    output csum,
`endif
    input  wr_en, wr_addr, wr_data, start, instr_ready, result_in,
    output instr_out, instr_valid, result, result_valid, busy, done
  );

  modport slave (
`ifdef ALU_ISSUER_CSUM_EN
    input  csum,
`endif
    output wr_en, wr_addr, wr_data, start, instr_ready, result_in,
    input  instr_out, instr_valid, result, result_valid, busy, done
  );
endinterface

// File: rtl/alu_prog_issuer.sv
// alu_prog_issuer
//   Streams a small program RAM to the tt_um_alu_fsm byte interface and
//   captures the ALU result RESULT_LAT cycles after every STORE is accepted.
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset (aborts any running program)
//     bus        alu_prog_issuer_if.master: wr_en/wr_addr/wr_data, start,
//                instr_out/instr_valid/instr_ready, result_in, result,
//                result_valid, busy, done (+ csum with ALU_ISSUER_CSUM_EN)
//     state_dbg  current FSM state for observation
//   Optional macro ALU_ISSUER_CSUM_EN: csum = mod-256 sum of every transferred
//   byte, cleared on reset and on start acceptance.
//   Instruction encoding: [7:6] 00=HALT 01=LOAD 10=ADD 11=STORE; 0x00 ends.
module alu_prog_issuer #(
  parameter int AW         = 4,
  parameter int RESULT_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  alu_prog_issuer_if.master   bus,
  output logic [2:0]          state_dbg
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_RES = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [3:0]    cnt;
  logic [7:0]    mem [DEPTH];

  assign state_dbg = state;

  // Program RAM, not reset. Writes only land while idle, so a write never
  // races the read that FETCH performs.
  always_ff @(posedge clk) begin
    if (bus.wr_en && state == S_IDLE) mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      pc               <= '0;
      cnt              <= '0;
      bus.instr_out    <= '0;
      bus.instr_valid  <= 1'b0;
      bus.result       <= '0;
      bus.result_valid <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
`ifdef ALU_ISSUER_CSUM_EN
      bus.csum         <= '0;
`endif
    end else begin
      bus.result_valid <= 1'b0;
      bus.done         <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.busy <= 1'b0;
          if (bus.start) begin
            pc       <= '0;
            bus.busy <= 1'b1;
            state    <= S_FETCH;
`ifdef ALU_ISSUER_CSUM_EN
            bus.csum <= '0;
`endif
          end
        end
        // instr_out doubles as the RAM read register; a 0x00 byte is loaded
        // with valid low so ISSUE can recognise the end of program.
        S_FETCH: begin
          bus.instr_out   <= mem[pc];
          bus.instr_valid <= (mem[pc] != 8'h00);
          state           <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!bus.instr_valid) begin
            bus.done <= 1'b1;
            state    <= S_DONE;
          end else if (bus.instr_ready) begin
            bus.instr_valid <= 1'b0;
`ifdef ALU_ISSUER_CSUM_EN
            bus.csum <= bus.csum + bus.instr_out;
`endif
            if (bus.instr_out[7:6] == 2'b11) begin
              cnt   <= 4'(RESULT_LAT);
              state <= S_WAIT_RES;
            end else if (pc == AW'(DEPTH - 1)) begin
              bus.done <= 1'b1;
              state    <= S_DONE;
            end else begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        // cnt==1 marks the RESULT_LAT-th edge after the STORE was accepted.
        S_WAIT_RES: begin
          if (cnt == 4'd1) begin
            bus.result       <= bus.result_in;
            bus.result_valid <= 1'b1;
            if (pc == AW'(DEPTH - 1)) begin
              bus.done <= 1'b1;
              state    <= S_DONE;
            end else begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
